// File: rtl/sram_fsm_host.sv
// Host-side controller for a simple SRAM: accepts one read or write request at a time,
// sequences the op/select command through WRITE/READ and SETTLE, then pulses a response.
module sram_fsm_host #(
  parameter int unsigned WR_CYCLES     = 2,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned RD_TIMEOUT    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [2:0] req_adr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       mem_op,
  output logic       mem_select,
  output logic [2:0] mem_adr,
  output logic [7:0] mem_in,
  input  logic [7:0] mem_out,
  input  logic       mem_valid
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    SETTLE,
    RESP
  } state_t;

  // Counters are loaded with N-1 on entry so a state lasts N cycles and exits at zero.
  localparam logic [7:0] WR_LOAD     = 8'(WR_CYCLES - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] RD_LOAD     = 8'(RD_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] adr_q, adr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       err_q, err_d;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          adr_d   = req_adr;
          wdata_d = req_wdata;
          if (req_we) begin
            state_d = WRITE;
            cnt_d   = WR_LOAD;
          end else begin
            state_d = READ;
            cnt_d   = RD_LOAD;
          end
        end
      end
      WRITE: begin
        if (cnt_q == 8'd0) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LOAD;
          rdata_d = 8'd0;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      READ: begin
        // mem_valid is only looked at here; stray pulses in other states are ignored.
        if (mem_valid) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LOAD;
          rdata_d = mem_out;
          err_d   = 1'b0;
        end else if (cnt_q == 8'd0) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LOAD;
          rdata_d = 8'd0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = RESP;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    // NOTE: reset clears every register here, including the latched address/data and response.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      adr_q   <= 3'd0;
      wdata_q <= 8'd0;
      rdata_q <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_op     = (state_q == WRITE);
  assign mem_select = (state_q == WRITE) || (state_q == READ);
  assign req_ready  = (state_q == IDLE) && !rst;
  assign rsp_valid  = (state_q == RESP);
  assign mem_adr    = adr_q;
  assign mem_in     = wdata_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_sram_fsm_host.sv
// Directed bench for sram_fsm_host with default parameters: reset, write, read,
// read timeout, held req_valid, stray mem_valid and mid-transaction reset.
module tb_sram_fsm_host;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [2:0] req_adr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       mem_op;
  logic       mem_select;
  logic [2:0] mem_adr;
  logic [7:0] mem_in;
  logic [7:0] mem_out;
  logic       mem_valid;

  int vectors     = 0;
  int miscompares = 0;
  bit illegal_seen = 1'b0;

  sram_fsm_host dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_adr    (req_adr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_op     (mem_op),
    .mem_select (mem_select),
    .mem_adr    (mem_adr),
    .mem_in     (mem_in),
    .mem_out    (mem_out),
    .mem_valid  (mem_valid)
  );

  always #5 clk = ~clk;

  // op=1,sel=0 must never appear; sampled mid-cycle.
  always @(negedge clk) if (mem_op && !mem_select) illegal_seen <= 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_adr = 3'd0; req_wdata = 8'd0;
    mem_out = 8'd0; mem_valid = 1'b0;
    tick(); tick();
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready: got %b want 0", req_ready);
    end
    vectors++;
    if ({mem_op, mem_select, mem_adr, mem_in} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_mem: got op/sel=%b%b adr=%h in=%h want 0", mem_op, mem_select, mem_adr, mem_in);
    end
    vectors++;
    if ({rsp_valid, rsp_rdata, rsp_err} !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_rsp: got v=%b d=%h e=%b want 0", rsp_valid, rsp_rdata, rsp_err);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_release_ready: got %b want 1", req_ready);
    end
  endtask

  // Write adr=000, wdata=55: op/sel 11,11,00,00 then RESP at E+5.
  task automatic test_write();
    logic [1:0] exp_cmd [4] = '{2'b11, 2'b11, 2'b00, 2'b00};
    req_valid = 1'b1; req_we = 1'b1; req_adr = 3'b000; req_wdata = 8'h55;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL write_ready: got %b want 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if ({mem_op, mem_select, rsp_valid} !== {exp_cmd[c], 1'b0}) begin
        miscompares++;
        $display("FAIL write_cmd E+%0d: got op/sel/rsp=%b%b%b want %b0", c + 1, mem_op, mem_select, rsp_valid, exp_cmd[c]);
      end
      tick();
    end
    vectors++;
    if ({rsp_valid, rsp_err, rsp_rdata, mem_in, mem_adr} !== {1'b1, 1'b0, 8'h00, 8'h55, 3'b000}) begin
      miscompares++;
      $display("FAIL write_resp: got v=%b e=%b d=%h in=%h adr=%h want v=1 e=0 d=00 in=55 adr=0", rsp_valid, rsp_err, rsp_rdata, mem_in, mem_adr);
    end
    tick();
    vectors++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      miscompares++; $display("FAIL write_after: got rsp/ready=%b%b want 01", rsp_valid, req_ready);
    end
  endtask

  // Read adr=000, mem_valid in the 3rd READ cycle -> RESP at E+6 with data 55.
  task automatic test_read_valid();
    req_valid = 1'b1; req_we = 1'b0; req_adr = 3'b000; mem_out = 8'h55; mem_valid = 1'b0;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      vectors++;
      if ({mem_op, mem_select} !== 2'b01) begin
        miscompares++; $display("FAIL read_cmd E+%0d: got op/sel=%b%b want 01", c, mem_op, mem_select);
      end
      if (c == 3) mem_valid = 1'b1;
      tick();
    end
    mem_valid = 1'b0; mem_out = 8'h00;
    for (int c = 4; c <= 5; c++) begin
      vectors++;
      if ({mem_op, mem_select, rsp_valid} !== 3'b000) begin
        miscompares++; $display("FAIL read_settle E+%0d: got op/sel/rsp=%b%b%b want 000", c, mem_op, mem_select, rsp_valid);
      end
      tick();
    end
    vectors++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 8'h55}) begin
      miscompares++; $display("FAIL read_resp: got v=%b e=%b d=%h want v=1 e=0 d=55", rsp_valid, rsp_err, rsp_rdata);
    end
    tick();
  endtask

  // mem_valid pulses while IDLE must not disturb the held read data.
  task automatic test_stray_valid();
    mem_valid = 1'b1; mem_out = 8'hAA;
    tick(); tick();
    mem_valid = 1'b0;
    tick();
    vectors++;
    if ({rsp_valid, rsp_rdata, rsp_err} !== {1'b0, 8'h55, 1'b0}) begin
      miscompares++; $display("FAIL stray_idle: got v=%b d=%h e=%b want v=0 d=55 e=0", rsp_valid, rsp_rdata, rsp_err);
    end
  endtask

  // No mem_valid: 8 READ cycles, 2 SETTLE cycles (one with a stray pulse), error response.
  task automatic test_timeout();
    int read_cycles = 0;
    req_valid = 1'b1; req_we = 1'b0; req_adr = 3'b011; mem_valid = 1'b0;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 12 && mem_select; c++) begin
      read_cycles++;
      tick();
    end
    vectors++;
    if (read_cycles !== 8) begin
      miscompares++; $display("FAIL timeout_len: got %0d READ cycles want 8", read_cycles);
    end
    mem_valid = 1'b1; mem_out = 8'hAA;
    tick();
    mem_valid = 1'b0;
    vectors++;
    if ({mem_op, mem_select, rsp_valid} !== 3'b000) begin
      miscompares++; $display("FAIL timeout_settle: got op/sel/rsp=%b%b%b want 000", mem_op, mem_select, rsp_valid);
    end
    tick();
    vectors++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 8'h00}) begin
      miscompares++; $display("FAIL timeout_resp: got v=%b e=%b d=%h want v=1 e=1 d=00", rsp_valid, rsp_err, rsp_rdata);
    end
    tick();
  endtask

  // req_valid held high with a changing address: one acceptance, next only after RESP.
  task automatic test_back_to_back();
    req_valid = 1'b1; req_we = 1'b1; req_adr = 3'b101; req_wdata = 8'h3C;
    tick();
    for (int c = 1; c <= 5; c++) begin
      req_adr = 3'(c); req_wdata = 8'(c);
      vectors++;
      if ({req_ready, mem_adr, mem_in, rsp_valid} !== {1'b0, 3'b101, 8'h3C, c == 5}) begin
        miscompares++;
        $display("FAIL b2b_busy E+%0d: got ready=%b adr=%h in=%h rsp=%b want 0/5/3c/%0d", c, req_ready, mem_adr, mem_in, rsp_valid, c == 5);
      end
      tick();
    end
    req_adr = 3'b011; req_wdata = 8'hC3;
    vectors++;
    if ({req_ready, mem_adr} !== {1'b1, 3'b101}) begin
      miscompares++; $display("FAIL b2b_idle: got ready=%b adr=%h want 1/5", req_ready, mem_adr);
    end
    tick();
    req_valid = 1'b0;
    vectors++;
    if ({mem_op, mem_select, mem_adr, mem_in} !== {2'b11, 3'b011, 8'hC3}) begin
      miscompares++; $display("FAIL b2b_second: got op/sel=%b%b adr=%h in=%h want 11/3/c3", mem_op, mem_select, mem_adr, mem_in);
    end
    repeat (4) tick();
    vectors++;
    if (rsp_valid !== 1'b1) begin
      miscompares++; $display("FAIL b2b_second_resp: got %b want 1", rsp_valid);
    end
    tick();
  endtask

  // Reset during the 2nd WRITE cycle aborts the transaction.
  task automatic test_reset_abort();
    bit rsp_seen = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_adr = 3'b110; req_wdata = 8'h99;
    tick();
    req_valid = 1'b0;
    tick();
    vectors++;
    if ({mem_op, mem_select} !== 2'b11) begin
      miscompares++; $display("FAIL abort_pre: got op/sel=%b%b want 11", mem_op, mem_select);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if ({mem_op, mem_select, rsp_valid, mem_adr, mem_in} !== 14'd0) begin
      miscompares++;
      $display("FAIL abort_post: got op/sel/rsp=%b%b%b adr=%h in=%h want 0", mem_op, mem_select, rsp_valid, mem_adr, mem_in);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL abort_ready: got %b want 1", req_ready);
    end
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid) rsp_seen = 1'b1;
      tick();
    end
    vectors++;
    if (rsp_seen !== 1'b0) begin
      miscompares++; $display("FAIL abort_rsp: got rsp_valid pulse want none");
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_valid();
    test_stray_valid();
    test_timeout();
    test_back_to_back();
    test_reset_abort();
    vectors++;
    if (illegal_seen !== 1'b0) begin
      miscompares++; $display("FAIL illegal_cmd: got op=1,sel=0 seen want never");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_fsm_host.md
SRAM_FSM_HOST -- requirements
Module: sram_fsm_host

Interface
REQ-001 Parameter WR_CYCLES, default 2: number of cycles the write command is held (1..255).
REQ-002 Parameter SETTLE_CYCLES, default 2: number of cycles the stable command is held after a write or read (1..255).
REQ-003 Parameter RD_TIMEOUT, default 8: maximum number of READ cycles spent waiting for mem_valid (1..255).
REQ-004 clk  input  1  single clock; all state changes occur on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req_valid  input  1  host request present.
REQ-007 req_ready  output  1  block is able to accept a request.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_adr  input  3  SRAM word address.
REQ-010 req_wdata  input  8  write data.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  8  read data, valid while rsp_valid=1.
REQ-013 rsp_err  output  1  read timeout flag, valid while rsp_valid=1.
REQ-014 mem_op  output  1  SRAM op input.
REQ-015 mem_select  output  1  SRAM select input.
REQ-016 mem_adr  output  3  SRAM address.
REQ-017 mem_in  output  8  SRAM write data.
REQ-018 mem_out  input  8  SRAM read data.
REQ-019 mem_valid  input  1  SRAM read data valid.

Function
REQ-020 SRAM command encoding SHALL be: op=0,sel=0 is STABLE/idle; op=1,sel=1 is WRITE; op=0,sel=1 is READ; op=1,sel=0 SHALL never be driven.
REQ-021 The FSM SHALL have the states IDLE, WRITE, READ, SETTLE and RESP. mem_op, mem_select, req_ready and rsp_valid SHALL be decoded from the state only (Moore outputs).
REQ-022 Command per state: WRITE drives op=1,sel=1; READ drives op=0,sel=1; IDLE, SETTLE and RESP drive op=0,sel=0.
REQ-023 req_ready SHALL be 1 only in IDLE, and 0 while rst=1.
REQ-024 Handshake: a request is accepted at a rising edge where req_valid=1, req_ready=1 and rst=0.
  - On acceptance, req_adr and req_wdata are latched into mem_adr and mem_in.
  - These values are held until the next acceptance.
REQ-025 After acceptance the FSM SHALL go to WRITE if req_we=1, otherwise to READ; while busy, req_* inputs are ignored.
REQ-026 WRITE: the FSM SHALL stay exactly WR_CYCLES cycles, then go to SETTLE.
REQ-027 READ: mem_valid is sampled on every READ cycle, including the first.
  - When mem_valid=1: capture mem_out into rsp_rdata, set the error flag to 0, go to SETTLE.
  - After RD_TIMEOUT READ cycles without mem_valid: set rsp_rdata=0 and the error flag to 1, go to SETTLE.
REQ-028 SETTLE: the FSM SHALL stay exactly SETTLE_CYCLES cycles, then go to RESP.
REQ-029 RESP: the FSM SHALL stay one cycle with rsp_valid=1, then go to IDLE. A request is not accepted in RESP.
REQ-030 For writes, rsp_rdata=0 and rsp_err=0. rsp_rdata and rsp_err SHALL hold their values until the next response is loaded.
REQ-031 Latency, with acceptance at edge E and defaults:
  - write: WRITE in cycles E+1..E+2, SETTLE in E+3..E+4, rsp_valid in E+5;
  - read with mem_valid in the k-th READ cycle: rsp_valid in cycle E+k+3.
REQ-032 mem_valid and mem_out SHALL be ignored outside READ.
REQ-033 Cycle counters SHALL be 8 bits wide and SHALL be reloaded on each state entry.

Reset
REQ-034 While rst=1 at an edge, the FSM SHALL enter IDLE, and the following SHALL be 0: mem_op, mem_select, mem_adr, mem_in, rsp_valid, rsp_rdata, rsp_err, and all counters.
REQ-035 rst asserted mid-transaction SHALL abort the transaction: no rsp_valid pulse and no WRITE/READ command in the cycle after the reset edge; req_ready=1 in the first cycle after rst is deasserted.

Verification
REQ-036 Reset, then write adr=000, wdata=01010101 -> op/sel=11 for exactly 2 cycles, then 00 for 2 cycles, rsp_valid one cycle at E+5 with rsp_err=0, mem_in=01010101.
REQ-037 Read adr=000, mem_valid=1 with mem_out=01010101 in the 3rd READ cycle -> op/sel=01 for 3 cycles, rsp_rdata=01010101, rsp_err=0, rsp_valid at E+6.
REQ-038 Read with mem_valid held at 0 -> exactly 8 READ cycles, then 2 SETTLE cycles, rsp_valid with rsp_err=1 and rsp_rdata=00000000.
REQ-039 req_valid held at 1 throughout a write, with req_adr changing -> only one acceptance per transaction, mem_adr unchanged, next acceptance only in the IDLE cycle after RESP.
REQ-040 rst pulsed for one cycle during the 2nd WRITE cycle -> op/sel=00 in the next cycle, no rsp_valid, req_ready=1 after release, mem_adr=000.
REQ-041 Throughout every test, op=1,sel=0 is never driven, and mem_valid pulses outside READ do not change rsp_rdata.
